// File: rtl/cdc_4phase_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : cdc_4phase_rr_arbiter
// Purpose  : Round-robin scheduler that shares one 4-phase CDC sender among
//            NumIn requester streams. The winner's payload and index are held
//            in a one-entry registered output stage until the CDC accepts it.
// Revision : 1.0 - initial release
// ============================================================================
module cdc_4phase_rr_arbiter #(
    parameter int NumIn     = 4,
    parameter int DataWidth = 32
) (
    input  logic                                      clk_i,
    input  logic                                      rst_ni,
    input  logic                                      en_i,
    input  logic [NumIn-1:0]                          req_valid_i,
    output logic [NumIn-1:0]                          req_ready_o,
    input  logic [NumIn*DataWidth-1:0]                req_data_i,
    output logic                                      cdc_valid_o,
    input  logic                                      cdc_ready_i,
    output logic [DataWidth-1:0]                      cdc_data_o,
    output logic [((NumIn > 1) ? $clog2(NumIn) : 1)-1:0] cdc_idx_o,
    output logic                                      idle_o
);

    localparam int IdxWidth = (NumIn > 1) ? $clog2(NumIn) : 1;

    typedef enum logic [0:0] {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_e;

    state_e                state_q;
    state_e                state_d;
    logic [IdxWidth-1:0]   last_q;
    logic [IdxWidth-1:0]   idx_q;
    logic [DataWidth-1:0]  data_q;

    logic [IdxWidth-1:0]   winner;
    logic [DataWidth-1:0]  win_data;
    logic                  any_valid;
    logic                  load_ok;
    logic                  load;
    logic                  drain;

    assign any_valid = |req_valid_i;
    assign drain     = (state_q == FULL) && cdc_ready_i;
    // The stage can accept a new item when empty or when it is emptying this
    // very cycle; that pass-through of cdc_ready_i gives 1 item/cycle.
    assign load_ok   = en_i && ((state_q == EMPTY) || drain);
    assign load      = load_ok && any_valid;

    // Round-robin search: walk offsets from far to near so the nearest valid
    // requester after last_q overwrites earlier candidates and wins.
    always_comb begin
        winner   = '0;
        win_data = '0;
        for (int k = NumIn; k >= 1; k--) begin
            int cand;
            cand = (int'(last_q) + k) % NumIn;
            if (req_valid_i[cand]) begin
                winner   = IdxWidth'(cand);
                win_data = req_data_i[cand*DataWidth +: DataWidth];
            end
        end
    end

    // Only the winner sees ready, and only when a load can actually happen.
    always_comb begin
        req_ready_o = '0;
        if (load) begin
            req_ready_o[winner] = 1'b1;
        end
    end

    // Output-stage next state: a load always leaves it FULL (covers the
    // simultaneous drain+load case); a drain alone empties it.
    always_comb begin
        state_d = state_q;
        if (load) begin
            state_d = FULL;
        end else if (drain) begin
            state_d = EMPTY;
        end
    end

    // Output-stage state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Payload, tag and priority pointer move only on an actual load, so a
    // stalled output neither changes its contents nor rotates priority.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            data_q <= '0;
            idx_q  <= '0;
            last_q <= IdxWidth'(NumIn - 1);
        end else if (load) begin
            data_q <= win_data;
            idx_q  <= winner;
            last_q <= winner;
        end
    end

    assign cdc_valid_o = (state_q == FULL);
    assign cdc_data_o  = data_q;
    assign cdc_idx_o   = idx_q;
    assign idle_o      = (state_q == EMPTY);

endmodule
`default_nettype wire

// File: tb/tb_cdc_4phase_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_cdc_4phase_rr_arbiter
// Purpose  : Self-checking bench for cdc_4phase_rr_arbiter (NumIn=4, 16-bit
//            payload). Vector table plus a scoreboard of granted items.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cdc_4phase_rr_arbiter;

    localparam int N  = 4;
    localparam int DW = 16;
    localparam int IW = 2;

    logic              clk = 1'b0;
    logic              rst_ni;
    logic              en_i;
    logic [N-1:0]      req_valid_i;
    logic [N-1:0]      req_ready_o;
    logic [N*DW-1:0]   req_data_i;
    logic              cdc_valid_o;
    logic              cdc_ready_i;
    logic [DW-1:0]     cdc_data_o;
    logic [IW-1:0]     cdc_idx_o;
    logic              idle_o;

    cdc_4phase_rr_arbiter #(.NumIn(N), .DataWidth(DW)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_ni),
        .en_i        (en_i),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_data_i  (req_data_i),
        .cdc_valid_o (cdc_valid_o),
        .cdc_ready_i (cdc_ready_i),
        .cdc_data_o  (cdc_data_o),
        .cdc_idx_o   (cdc_idx_o),
        .idle_o      (idle_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [N-1:0]  valid;
        logic          rdy;
        logic          en;
        logic [N-1:0]  exp_ready;
        logic          exp_cv;
        logic [IW-1:0] exp_idx;
    } vec_t;

    typedef struct packed {
        logic [IW-1:0] idx;
        logic [DW-1:0] data;
    } item_t;

    vec_t          vecs[$];
    item_t         sb[$];
    logic [DW-1:0] base;
    int            tests = 0;
    int            fails = 0;

    function automatic vec_t mk(logic [N-1:0] v, logic r, logic e,
                                logic [N-1:0] xr, logic xv, logic [IW-1:0] xi);
        vec_t t;
        t.valid = v; t.rdy = r; t.en = e;
        t.exp_ready = xr; t.exp_cv = xv; t.exp_idx = xi;
        return t;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] dat(int i);
        return base + DW'(i);
    endfunction

    // Drive one vector, check at the falling edge, advance past the rising edge.
    task automatic run_row(int n, vec_t v);
        req_valid_i = v.valid;
        cdc_ready_i = v.rdy;
        en_i        = v.en;
        for (int i = 0; i < N; i++) req_data_i[i*DW +: DW] = dat(i);
        @(negedge clk);
        chk($sformatf("row%0d ready", n), 32'(req_ready_o), 32'(v.exp_ready));
        chk($sformatf("row%0d valid", n), 32'(cdc_valid_o), 32'(v.exp_cv));
        chk($sformatf("row%0d idle", n), 32'(idle_o), 32'(!v.exp_cv));
        if (v.exp_cv) begin
            chk($sformatf("row%0d idx", n), 32'(cdc_idx_o), 32'(v.exp_idx));
            if (sb.size() == 0) begin
                chk($sformatf("row%0d sb_empty", n), 32'(1), 32'(0));
            end else begin
                chk($sformatf("row%0d sb_idx", n), 32'(cdc_idx_o), 32'(sb[0].idx));
                chk($sformatf("row%0d sb_data", n), 32'(cdc_data_o), 32'(sb[0].data));
                if (v.rdy) void'(sb.pop_front());
            end
        end
        for (int i = 0; i < N; i++) begin
            if (v.exp_ready[i]) begin
                item_t it;
                it.idx  = IW'(i);
                it.data = dat(i);
                sb.push_back(it);
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_ni      = 1'b0;
        en_i        = 1'b1;
        req_valid_i = '0;
        cdc_ready_i = 1'b0;
        req_data_i  = '0;
        base        = 16'h0010;

        // Reset values while reset is held.
        #23;
        chk("reset valid", 32'(cdc_valid_o), 32'(0));
        chk("reset data", 32'(cdc_data_o), 32'(0));
        chk("reset idx", 32'(cdc_idx_o), 32'(0));
        chk("reset idle", 32'(idle_o), 32'(1));
        chk("reset ready", 32'(req_ready_o), 32'(0));
        @(posedge clk);
        #1;
        rst_ni = 1'b1;

        //                 valid    rdy  en  exp_ready cv idx
        vecs.push_back(mk(4'b0000, 1'b1, 1'b1, 4'b0000, 1'b0, 2'd0));
        // All valid, CDC always ready: grants 0,1,2,3,0 back to back.
        vecs.push_back(mk(4'b1111, 1'b1, 1'b1, 4'b0001, 1'b0, 2'd0));
        vecs.push_back(mk(4'b1111, 1'b1, 1'b1, 4'b0010, 1'b1, 2'd0));
        vecs.push_back(mk(4'b1111, 1'b1, 1'b1, 4'b0100, 1'b1, 2'd1));
        vecs.push_back(mk(4'b1111, 1'b1, 1'b1, 4'b1000, 1'b1, 2'd2));
        vecs.push_back(mk(4'b1111, 1'b1, 1'b1, 4'b0001, 1'b1, 2'd3));
        // Only requester 2, then a 5-cycle stall: no further grant, held entry.
        vecs.push_back(mk(4'b0100, 1'b1, 1'b1, 4'b0100, 1'b1, 2'd0));
        for (int i = 0; i < 5; i++)
            vecs.push_back(mk(4'b0100, 1'b0, 1'b1, 4'b0000, 1'b1, 2'd2));
        vecs.push_back(mk(4'b0000, 1'b1, 1'b1, 4'b0000, 1'b1, 2'd2));
        vecs.push_back(mk(4'b0000, 1'b1, 1'b1, 4'b0000, 1'b0, 2'd0));
        // Load idx 1, then disable: entry drains, no grants despite 1111.
        vecs.push_back(mk(4'b0010, 1'b1, 1'b1, 4'b0010, 1'b0, 2'd0));
        vecs.push_back(mk(4'b1111, 1'b1, 1'b0, 4'b0000, 1'b1, 2'd1));
        vecs.push_back(mk(4'b1111, 1'b1, 1'b0, 4'b0000, 1'b0, 2'd0));
        // Re-enable: resumes after preserved last_q=1, so requester 2.
        vecs.push_back(mk(4'b1111, 1'b0, 1'b1, 4'b0100, 1'b0, 2'd0));
        vecs.push_back(mk(4'b0000, 1'b1, 1'b1, 4'b0000, 1'b1, 2'd2));
        vecs.push_back(mk(4'b0000, 1'b1, 1'b1, 4'b0000, 1'b0, 2'd0));
        // last_q=1, then 0001/1001 patterns: search 2,3,0 picks 3 first.
        vecs.push_back(mk(4'b0010, 1'b1, 1'b1, 4'b0010, 1'b0, 2'd0));
        vecs.push_back(mk(4'b1001, 1'b1, 1'b1, 4'b1000, 1'b1, 2'd1));
        // last_q=3 with 0 and 3 valid: drain+load, idx 3 then 0 without bubble.
        vecs.push_back(mk(4'b1001, 1'b1, 1'b1, 4'b0001, 1'b1, 2'd3));
        vecs.push_back(mk(4'b1001, 1'b1, 1'b1, 4'b1000, 1'b1, 2'd0));
        vecs.push_back(mk(4'b0001, 1'b1, 1'b1, 4'b0001, 1'b1, 2'd3));
        vecs.push_back(mk(4'b0000, 1'b1, 1'b1, 4'b0000, 1'b1, 2'd0));
        vecs.push_back(mk(4'b0000, 1'b1, 1'b1, 4'b0000, 1'b0, 2'd0));

        for (int n = 0; n < vecs.size(); n++) run_row(n, vecs[n]);

        // Async reset while FULL: outputs clear immediately, without a clock.
        base = 16'h00A0;
        run_row(100, mk(4'b0100, 1'b0, 1'b1, 4'b0100, 1'b0, 2'd0));
        run_row(101, mk(4'b0000, 1'b0, 1'b1, 4'b0000, 1'b1, 2'd2));
        #2;
        rst_ni = 1'b0;
        #1;
        chk("async rst valid", 32'(cdc_valid_o), 32'(0));
        chk("async rst idle", 32'(idle_o), 32'(1));
        chk("async rst data", 32'(cdc_data_o), 32'(0));
        sb.delete();
        @(posedge clk);
        #1;
        rst_ni = 1'b1;
        // After release requester 0 has first priority again.
        run_row(102, mk(4'b1111, 1'b1, 1'b1, 4'b0001, 1'b0, 2'd0));
        run_row(103, mk(4'b0000, 1'b1, 1'b1, 4'b0000, 1'b1, 2'd0));
        run_row(104, mk(4'b0000, 1'b1, 1'b1, 4'b0000, 1'b0, 2'd0));
        chk("sb drained", 32'(sb.size()), 32'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
